axiline_train_scheduler: RTL and testbench

- Top-level sequencer for the Axiline three-stage training pipeline: inner-product accumulate, then gradient comb, then SGD weight update.
- Streams each sample in NUM_CYCLE chunks through a valid/ready handshake with the operand feeder.
- Drives the ip psum select and the comb valid strobe, and issues the SGD write-back strobe at the correct pipeline depth.
- Iterates over samples and epochs, and enforces a weight read-after-write gap between consecutive samples.

---
 rtl/axiline_pkg.sv | 16 +
 rtl/wb_delay_line.sv | 30 +++
 rtl/axiline_train_scheduler.sv | 155 +++++++++++++++
 tb/tb_axiline_train_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/axiline_pkg.sv
// Shared definitions for the Axiline training accelerator: scheduler states
// and default pipeline geometry reused by the accelerator top.
package axiline_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int NUM_CYCLE_DEF = 8;
  localparam int WB_DELAY_DEF  = 2;
  localparam int GAP_DEF       = 3;

endpackage

// File: rtl/wb_delay_line.sv
// Single-bit pipeline delay of DEPTH cycles with asynchronous active-low clear;
// o_any reports whether any pulse is still in flight.
module wb_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_any
);

  logic [DEPTH-1:0] r_sr;

  // shift register: every pulse advances one stage per cycle, none merge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_q   = r_sr[DEPTH-1];
  assign o_any = |r_sr;

endmodule

// File: rtl/axiline_train_scheduler.sv
// Axiline training sequencer: streams NUM_CYCLE chunks per sample through the
// ip/comb/sgd pipeline over all samples and epochs, then drains write-backs.
module axiline_train_scheduler
  import axiline_pkg::*;
#(
  parameter int NUM_CYCLE     = NUM_CYCLE_DEF,
  parameter int LOG_NUM_CYCLE = 3,
  parameter int SAMPLE_W      = 16,
  parameter int EPOCH_W       = 8,
  parameter int WB_DELAY      = WB_DELAY_DEF,
  parameter int GAP           = GAP_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SAMPLE_W-1:0]      num_samples,
  input  logic [EPOCH_W-1:0]       num_epochs,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     sel,
  output logic [LOG_NUM_CYCLE-1:0] chunk_idx,
  output logic                     grad_valid,
  output logic                     w_wr_en,
  output logic [SAMPLE_W-1:0]      sample_idx,
  output logic [EPOCH_W-1:0]       epoch_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int GAP_W = (GAP < 1) ? 1 : $clog2(GAP + 1);

  state_e                   r_state;
  logic [SAMPLE_W-1:0]      r_num_samples;
  logic [EPOCH_W-1:0]       r_num_epochs;
  logic [LOG_NUM_CYCLE-1:0] r_chunk;
  logic                     r_sel;
  logic [SAMPLE_W-1:0]      r_sample;
  logic [EPOCH_W-1:0]       r_epoch;
  logic [GAP_W-1:0]         r_gap;
  logic                     r_grad;
  logic                     r_busy;
  logic                     r_done;

  logic w_accept;
  logic w_last_chunk;
  logic w_last_sample;
  logic w_last_epoch;
  logic w_wb_q;
  logic w_line_busy;

  assign in_ready      = (r_state == LOAD) && (r_gap == '0);
  assign w_accept      = in_valid && in_ready;
  assign w_last_chunk  = (r_chunk == LOG_NUM_CYCLE'(NUM_CYCLE - 1));
  assign w_last_sample = (r_sample == r_num_samples - SAMPLE_W'(1));
  assign w_last_epoch  = (r_epoch == r_num_epochs - EPOCH_W'(1));

  // run sequencer: chunk/sample/epoch iteration, RAW gap and grad strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_num_samples <= '0;
      r_num_epochs  <= '0;
      r_chunk       <= '0;
      r_sel         <= 1'b0;
      r_sample      <= '0;
      r_epoch       <= '0;
      r_gap         <= '0;
      r_grad        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_grad <= 1'b0;
      r_done <= 1'b0;
      if (r_gap != '0) begin
        r_gap <= r_gap - GAP_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_num_samples <= num_samples;
            r_num_epochs  <= num_epochs;
            r_chunk       <= '0;
            r_sel         <= 1'b0;
            r_sample      <= '0;
            r_epoch       <= '0;
            r_gap         <= '0;
            r_busy        <= 1'b1;
            if ((num_samples == '0) || (num_epochs == '0)) begin
              r_state <= DONE;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (w_accept) begin
            if (w_last_chunk) begin
              r_chunk <= '0;
              r_sel   <= 1'b0;
              r_grad  <= 1'b1;
              r_gap   <= GAP_W'(GAP);
              if (w_last_sample) begin
                r_sample <= '0;
                if (w_last_epoch) begin
                  r_state <= DRAIN;
                end else begin
                  r_epoch <= r_epoch + EPOCH_W'(1);
                end
              end else begin
                r_sample <= r_sample + SAMPLE_W'(1);
              end
            end else begin
              r_chunk <= r_chunk + LOG_NUM_CYCLE'(1);
              r_sel   <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // the final grad strobe is not yet in the delay line on its first cycle
          if (!r_grad && !w_line_busy) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  wb_delay_line #(
    .DEPTH (WB_DELAY)
  ) u_wb_delay_line (
    .clk   (clk),
    .rst_n (rst),
    .i_d   (r_grad),
    .o_q   (w_wb_q),
    .o_any (w_line_busy)
  );

  assign sel        = r_sel;
  assign chunk_idx  = r_chunk;
  assign grad_valid = r_grad;
  assign w_wr_en    = w_wb_q;
  assign sample_idx = r_sample;
  assign epoch_idx  = r_epoch;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_axiline_train_scheduler.sv
// Randomized bench for axiline_train_scheduler: a progress-count reference model
// predicts ready/index/strobe behaviour each cycle.
module tb_axiline_train_scheduler;

  localparam int N    = 8;
  localparam int WB   = 2;
  localparam int GAPC = 3;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_samples = 16'd0;
  logic [7:0]  num_epochs = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sel;
  logic [2:0]  chunk_idx;
  logic        grad_valid;
  logic        w_wr_en;
  logic [15:0] sample_idx;
  logic [7:0]  epoch_idx;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  bit comp [MAXC];

  always #5 clk = ~clk;

  axiline_train_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .num_epochs  (num_epochs),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sel         (sel),
    .chunk_idx   (chunk_idx),
    .grad_valid  (grad_valid),
    .w_wr_en     (w_wr_en),
    .sample_idx  (sample_idx),
    .epoch_idx   (epoch_idx),
    .busy        (busy),
    .done        (done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: progress is just the number of accepted chunks k; everything else
  // (indices, sample completions, strobe times) follows arithmetically from k.
  task automatic run_train(input int s, input int e, input int vprob, input bit poke);
    int  t, k, tot, last_c, last_wr, done_t, ng, nw, nd, c;
    bit  exp_rdy, exp_wr;
    tot = N * s * e;
    k = 0; c = 0; last_c = -1000; last_wr = -1; done_t = -1; ng = 0; nw = 0; nd = 0;
    foreach (comp[i]) comp[i] = 1'b0;
    @(negedge clk);
    start = 1'b1; num_samples = 16'(s); num_epochs = 8'(e); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (t = 1; t < MAXC - 8; t++) begin
      in_valid = ($urandom_range(0, 99) < vprob);
      start = poke && (k < tot) && ($urandom_range(0, 15) == 0);
      if (poke) begin
        num_samples = 16'($urandom);
        num_epochs  = 8'($urandom);
      end
      #1;
      exp_rdy = (k < tot) && (t - last_c > GAPC);
      check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (k < tot) begin
        c = k % N;
        check_val("chunk_idx", 32'(chunk_idx), 32'(c));
        check_val("sel", 32'(sel), 32'(c != 0));
        check_val("sample_idx", 32'(sample_idx), 32'((k / N) % s));
        check_val("epoch_idx", 32'(epoch_idx), 32'(k / (N * s)));
      end
      check_val("grad_valid", 32'(grad_valid), 32'(comp[t-1]));
      exp_wr = (t - 1 - WB >= 0) ? comp[t-1-WB] : 1'b0;
      check_val("w_wr_en", 32'(w_wr_en), 32'(exp_wr));
      if (grad_valid) ng++;
      if (w_wr_en) nw++;
      if ((k < tot) || (t <= last_wr)) check_val("busy", 32'(busy), 32'd1);
      if (done) begin
        nd++;
        if (done_t < 0) done_t = t;
        check_val("done_window", 32'((t > last_wr) && (t <= last_wr + 4) && (k == tot)), 32'd1);
      end
      if ((done_t > 0) && (t == done_t + 2)) begin
        check_val("busy_after_done", 32'(busy), 32'd0);
        break;
      end
      if (in_valid && exp_rdy) begin
        if (c == N - 1) begin
          comp[t] = 1'b1;
          last_c = t;
          last_wr = t + 1 + WB;
        end
        k++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (done_t < 0) check_val("done_timeout", 32'd0, 32'd1);
    check_val("grad_count", 32'(ng), 32'(s * e));
    check_val("wr_count", 32'(nw), 32'(s * e));
    check_val("done_count", 32'(nd), 32'd1);
  endtask

  task automatic run_zero(input int s, input int e);
    @(negedge clk);
    start = 1'b1; num_samples = 16'(s); num_epochs = 8'(e); in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_val("zero_ready_c1", 32'(in_ready), 32'd0);
    check_val("zero_done_c1", 32'(done), 32'd0);
    @(negedge clk);
    #1;
    check_val("zero_done_c2", 32'(done), 32'd1);
    check_val("zero_ready_c2", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    check_val("zero_done_c3", 32'(done), 32'd0);
    check_val("zero_busy_c3", 32'(busy), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic reset_midrun(input int s, input bit pend);
    bit hit;
    hit = 1'b0;
    @(negedge clk);
    start = 1'b1; num_samples = 16'(s); num_epochs = 8'd1; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (pend ? (grad_valid === 1'b1) : ((chunk_idx == 3'd5) && (in_ready === 1'b1))) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("rst_trigger", 32'(hit), 32'd1);
    if (pend) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_chunk", 32'(chunk_idx), 32'd0);
    check_val("rst_sel", 32'(sel), 32'd0);
    check_val("rst_grad", 32'(grad_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    for (int t = 0; t < 6; t++) begin
      #1;
      check_val("rst_no_wr", 32'(w_wr_en), 32'd0);
      check_val("rst_no_done", 32'(done), 32'd0);
      check_val("rst_idle", 32'(busy), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val("reset_ready", 32'(in_ready), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_chunk", 32'(chunk_idx), 32'd0);
    check_val("reset_sample", 32'(sample_idx), 32'd0);
    check_val("reset_epoch", 32'(epoch_idx), 32'd0);
    check_val("reset_grad", 32'(grad_valid), 32'd0);
    check_val("reset_wr", 32'(w_wr_en), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_train(2, 1, 100, 1'b0);
    run_train(1, 3, 100, 1'b0);
    run_train(1, 1, 45, 1'b0);
    run_train(3, 2, 60, 1'b1);
    run_zero(0, 3);
    run_zero(5, 0);
    reset_midrun(1, 1'b0);
    reset_midrun(2, 1'b1);
    for (int r = 0; r < 4; r++) begin
      run_train($urandom_range(1, 3), $urandom_range(1, 2), $urandom_range(30, 100), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
